// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data-access ports.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic        dm_wr_en,
  input  logic [31:0] dm_wr_data,
  input  logic [3:0]  dm_byte_en,
  output logic        dm_ready,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rd_data
);

  localparam int unsigned CntW = 4;

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT or STARVE_MAX out of range");
  end

  logic grant_if;
  logic grant_dm;
  logic force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts cycles fetch waited while data won; hitting the limit hands one grant to fetch.
  logic [CntW-1:0] starve_q;
  logic [CntW-1:0] starve_d;

  assign force_if = (starve_q == CntW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (force_if || grant_if) begin
      starve_d = '0;
    end else if (if_req && grant_dm) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Data has priority unless the starvation guard forces a fetch grant.
  always_comb begin
    grant_dm = ~rst & dm_req & ~(force_if & if_req);
    grant_if = ~rst & if_req & ~grant_dm;
  end

  assign if_ready = grant_if;
  assign dm_ready = grant_dm;
  assign mem_req  = grant_if | grant_dm;

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    mem_byte_en = '0;
    if (grant_dm) begin
      mem_addr    = dm_addr;
      mem_wr_en   = dm_wr_en;
      mem_wr_data = dm_wr_data;
      mem_byte_en = dm_byte_en;
    end else if (grant_if) begin
      mem_addr    = if_addr;
      mem_byte_en = 4'hF;
    end
  end

  // In-flight tracker: one {valid, owner} slot per cycle of read latency; owner 1 = fetch.
  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] vld_d;
  logic [MEM_LAT-1:0] own_q;
  logic [MEM_LAT-1:0] own_d;

  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = grant_if | (grant_dm & ~dm_wr_en);
    own_d[0] = grant_if;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
    if (if_flush) begin
      vld_d = vld_d & ~own_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  logic tail_vld;
  logic tail_if;

  assign tail_vld = vld_q[MEM_LAT-1] & ~rst;
  assign tail_if  = own_q[MEM_LAT-1];

  // A fetch response landing in a flush cycle belongs to the discarded path.
  always_comb begin
    if_rsp_valid = tail_vld & tail_if & ~if_flush;
    dm_rsp_valid = tail_vld & ~tail_if;
    if_rsp_data  = if_rsp_valid ? mem_rd_data : '0;
    dm_rsp_data  = dm_rsp_valid ? mem_rd_data : '0;
  end

endmodule
